axi_slave_ram: RTL and testbench
================================

// Module: axi_slave_ram
// PURPOSE
//  AXI4 subordinate (responder) backed by a single-port word RAM; answers the AR/R/AW/W/B subset driven by mod_main masters.
//  Sits on the far end of a master port as a synthesizable memory target for system benches and FPGA bring-up.
//  Serves one burst at a time (read or write), INCR bursts only.
// PARAMETERS
//  ADDR_WIDTH      32  byte-address width of ARADDR/AWADDR
//  DATA_WIDTH      32  data bus width; byte lanes = DATA_WIDTH/8
//  MEM_DEPTH_LOG2  10  log2 of RAM depth in words (default 1024 words)
// PORTS
//  clk      in   1           clock; all logic on rising edge
//  rst      in   1           synchronous, active-high reset
//  ARADDR   in   ADDR_WIDTH  read burst start byte address
//  ARVALID  in   1           read address valid
//  ARREADY  out  1           read address accepted
//  ARLEN    in   8           read beats minus one
//  ARSIZE   in   3           beat size; ignored, bus width assumed
//  RVALID   out  1           read data valid
//  RDATA    out  DATA_WIDTH  read data
//  RREADY   in   1           master accepts read beat
//  RLAST    out  1           final read beat
//  AWADDR   in   ADDR_WIDTH  write burst start byte address
//  AWVALID  in   1           write address valid
//  AWREADY  out  1           write address accepted
//  AWLEN    in   8           write beats minus one
//  AWSIZE   in   3           beat size; ignored
//  WVALID   in   1           write data valid
//  WREADY   out  1           write data accepted
//  WDATA    in   DATA_WIDTH  write data
//  WLAST    in   1           final write beat from master
//  BVALID   out  1           write response valid
//  BREADY   in   1           master accepts response
//  BRESP    out  2           response code: 0 OKAY, 2 SLVERR
// BEHAVIOUR
//  Reset: state IDLE; ARREADY, AWREADY, RVALID, RLAST, WREADY, BVALID = 0; RDATA = 0; BRESP = 0; beat counter = 0; RAM contents untouched.
//  FSM: IDLE -> RADDR -> RDATA -> IDLE; IDLE -> WDATA -> WRESP -> IDLE.
//  IDLE: ARREADY = AWREADY = 1 (registered, high only in IDLE, drops the cycle after a handshake).
//  ARVALID and AWVALID both high in IDLE: read wins; AWREADY forced 0 that cycle, write stays pending.
//  AR handshake: latch word index = ARADDR[MEM_DEPTH_LOG2+1:2], count = ARLEN; RADDR issues RAM read; RVALID rises 2 cycles after the handshake cycle.
//  RDATA state: RDATA/RLAST held stable while RVALID && !RREADY.
//    On RVALID && RREADY: count==0 -> RVALID=0, RLAST=0, IDLE; else index+1, next beat valid 1 cycle later (one bubble per beat allowed).
//  RLAST = 1 exactly on the beat where count==0; ARLEN=0 gives a single beat with RLAST=1.
//  AW handshake: latch index/count from AWADDR/AWLEN; enter WDATA with WREADY=1.
//  WDATA: each WVALID && WREADY writes WDATA to RAM[index] that cycle; index+1, count-1.
//    Write on count==0 -> WREADY=0, BVALID=1, WRESP.
//  WRESP: BVALID/BRESP held until BREADY; then BVALID=0 and IDLE (BRESP returns to 0).
//  Index wrap: increments modulo 2^MEM_DEPTH_LOG2; upper address bits and addr[1:0] ignored.
//  Beat count is 8-bit; 256-beat bursts supported.
//  rst mid-burst: burst abandoned, all outputs to reset values next edge; a beat in flight is not written.
// CONFIGURATION
//  AXI_SLV_RESP_CHECK_EN defined: WLAST is checked against the beat counter.
//    WLAST=1 with count!=0 ends burst early.
//    count==0 with WLAST=0 also ends it.
//    Either case gives BRESP=2'b10 (SLVERR); beats already accepted remain written.
//  AXI_SLV_RESP_CHECK_EN undefined: WLAST ignored; burst length set by AWLEN alone; BRESP always 2'b00.
// STRUCTURE
//  Package axi_slv_pkg:
//    state enum {IDLE,RADDR,RDATA,WDATA,WRESP}
//    constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
//  Sub-module axi_slv_ram_mem: single-port RAM, 1-cycle registered read, write-enable port; FSM/counters stay in axi_slave_ram.
// TESTING
//  Write AWADDR=0x10, AWLEN=3, WDATA 1..4 -> WREADY per beat, BVALID, BRESP=0; RAM[4..7]=1..4.
//  Read ARADDR=0x10, ARLEN=3, RREADY=1 -> RDATA 1,2,3,4; RLAST only on 4th; ARREADY high again after.
//  Same read with RREADY toggling 1/0 -> RDATA and RLAST stable during stalls, no beat lost or repeated.
//  ARVALID and AWVALID raised same cycle -> read completes first; AW accepted in following IDLE; BRESP=0.
//  Write AWADDR=0xFFC (last word), AWLEN=1, WDATA A,B -> RAM[1023]=A, RAM[0]=B; readback matches.
//  With AXI_SLV_RESP_CHECK_EN: AWLEN=3, WLAST on 2nd beat -> BRESP=2'b10, 2 words written. rst mid-read -> RVALID=0 next edge.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// rtl/axi_slv_pkg.sv - shared state encoding and response codes for the AXI RAM subordinate
package axi_slv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WDATA,
    WRESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_slv_ram_mem.sv
// rtl/axi_slv_ram_mem.sv - single-port word RAM, read-first, 1-cycle registered read
module axi_slv_ram_mem #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  // Array is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_slave_ram.sv
// rtl/axi_slave_ram.sv - AXI4 INCR-burst subordinate backed by a word RAM, one burst at a time
// Optional: AXI_SLV_RESP_CHECK_EN checks WLAST against the beat count and reports SLVERR.
module axi_slave_ram #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  output logic                  RVALID,
  output logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RREADY,
  output logic                  RLAST,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP
);
  import axi_slv_pkg::*;

  localparam logic [MEM_DEPTH_LOG2-1:0] IDX_ONE = 1;

  state_t                    state_q, state_d;
  logic [MEM_DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      ready_q, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic                      wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      mem_we, w_end, w_err;
  logic                      unused_ok;

`ifdef AXI_SLV_RESP_CHECK_EN
  assign w_end = WLAST || (cnt_q == 8'd0);
  assign w_err = WLAST != (cnt_q == 8'd0);
  assign unused_ok = ^{ARSIZE, AWSIZE, ARADDR, AWADDR};
`else
  assign w_end = (cnt_q == 8'd0);
  assign w_err = 1'b0;
  assign unused_ok = ^{ARSIZE, AWSIZE, ARADDR, AWADDR, WLAST};
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    wready_d = wready_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    mem_we   = 1'b0;
    unique case (state_q)
      axi_slv_pkg::IDLE: begin
        // Read takes priority when both address channels are valid.
        if (ARVALID && ready_q) begin
          idx_d   = ARADDR[MEM_DEPTH_LOG2+1:2];
          cnt_d   = ARLEN;
          state_d = axi_slv_pkg::RADDR;
        end else if (AWVALID && ready_q) begin
          idx_d    = AWADDR[MEM_DEPTH_LOG2+1:2];
          cnt_d    = AWLEN;
          wready_d = 1'b1;
          state_d  = axi_slv_pkg::WDATA;
        end
      end
      axi_slv_pkg::RADDR: begin
        rvalid_d = 1'b1;
        rlast_d  = (cnt_q == 8'd0);
        state_d  = axi_slv_pkg::RDATA;
      end
      axi_slv_pkg::RDATA: begin
        // rvalid low here is the bubble while the RAM fetches the next word.
        if (rvalid_q) begin
          if (RREADY) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            if (cnt_q == 8'd0) begin
              state_d = axi_slv_pkg::IDLE;
            end else begin
              idx_d = idx_q + IDX_ONE;
              cnt_d = cnt_q - 8'd1;
            end
          end
        end else begin
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == 8'd0);
        end
      end
      axi_slv_pkg::WDATA: begin
        if (WVALID && wready_q) begin
          mem_we = 1'b1;
          idx_d  = idx_q + IDX_ONE;
          cnt_d  = cnt_q - 8'd1;
          if (w_end) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = w_err ? RESP_SLVERR : RESP_OKAY;
            state_d  = axi_slv_pkg::WRESP;
          end
        end
      end
      axi_slv_pkg::WRESP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
          state_d  = axi_slv_pkg::IDLE;
        end
      end
      default: state_d = axi_slv_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= axi_slv_pkg::IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ready_q  <= (state_d == axi_slv_pkg::IDLE);
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  axi_slv_ram_mem #(
    .DEPTH_LOG2 (MEM_DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we && !rst),
    .addr  (idx_q),
    .wdata (WDATA),
    .rdata (RDATA)
  );

  assign ARREADY = ready_q;
  assign AWREADY = ready_q && !ARVALID;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;

endmodule

// File: tb/tb_axi_slave_ram.sv
// tb/tb_axi_slave_ram.sv - directed bench for axi_slave_ram (AXI_SLV_RESP_CHECK_EN steps included when defined)
module tb_axi_slave_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  BRESP;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] model [1024];

  always #5 clk = ~clk;

  axi_slave_ram dut (
    .clk(clk), .rst(rst),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .RVALID(RVALID), .RDATA(RDATA), .RREADY(RREADY), .RLAST(RLAST),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [31:0] base,
                          input int nbeats, input int wlast_at, input logic [1:0] exp_resp);
    int k;
    AWADDR = a; AWLEN = len; AWVALID = 1'b1;
    #1;
    k = 0;
    while (!AWREADY && k < 20) begin tick(); #1; k++; end
    check("aw_handshake", k < 20, 1);
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      WDATA = base + i; WVALID = 1'b1; WLAST = (i == wlast_at);
      #1;
      check("wready", WREADY, 1);
      model[((a >> 2) + i) % 1024] = base + i;
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check("wready_after", WREADY, 0);
    check("bvalid", BVALID, 1);
    check("bresp", BRESP, exp_resp);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("bvalid_clear", BVALID, 0);
    check("bresp_clear", BRESP, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input bit stall);
    int k;
    logic [31:0] held;
    logic        held_last;
    ARADDR = a; ARLEN = len; ARVALID = 1'b1;
    #1;
    k = 0;
    while (!ARREADY && k < 20) begin tick(); #1; k++; end
    check("ar_handshake", k < 20, 1);
    tick();
    ARVALID = 1'b0;
    check("rvalid_early", RVALID, 0);
    for (int i = 0; i <= int'(len); i++) begin
      k = 0;
      while (!RVALID && k < 10) begin tick(); k++; end
      if (i == 0) check("r_latency", k, 1);
      else        check("r_beat_wait", k < 10, 1);
      if (stall) begin
        held = RDATA; held_last = RLAST;
        tick();
        check("stall_rvalid", RVALID, 1);
        check("stall_rdata", RDATA, held);
        check("stall_rlast", RLAST, held_last);
      end
      check("rdata", RDATA, model[((a >> 2) + i) % 1024]);
      check("rlast", RLAST, i == int'(len));
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
    end
    check("rvalid_end", RVALID, 0);
    check("rlast_end", RLAST, 0);
    check("arready_end", ARREADY, 1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    ARADDR = '0; ARVALID = 0; ARLEN = '0; ARSIZE = 3'd2; RREADY = 0;
    AWADDR = '0; AWVALID = 0; AWLEN = '0; AWSIZE = 3'd2;
    WVALID = 0; WDATA = '0; WLAST = 0; BREADY = 0;
    tick(); tick();
    check("rst_arready", ARREADY, 0);
    check("rst_awready", AWREADY, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rlast", RLAST, 0);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_bresp", BRESP, 0);
    rst = 1'b0;
    tick();

    do_write(32'h10, 8'd3, 32'd1, 4, 3, 2'b00);
    do_read(32'h10, 8'd3, 1'b0);
    do_read(32'h10, 8'd3, 1'b1);

    // Simultaneous AR and AW: read first, write accepted afterwards.
    ARADDR = 32'h10; ARLEN = 8'd0; ARVALID = 1'b1;
    AWADDR = 32'h40; AWLEN = 8'd0; AWVALID = 1'b1;
    #1;
    check("col_arready", ARREADY, 1);
    check("col_awready", AWREADY, 0);
    tick();
    ARVALID = 1'b0;
    #1;
    check("col_awready_busy", AWREADY, 0);
    k = 0;
    while (!RVALID && k < 10) begin tick(); k++; end
    check("col_rdata", RDATA, 32'd1);
    check("col_rlast", RLAST, 1);
    RREADY = 1'b1; tick(); RREADY = 1'b0;
    #1;
    check("col_awready_idle", AWREADY, 1);
    tick();
    AWVALID = 1'b0;
    WDATA = 32'h55; WVALID = 1'b1; WLAST = 1'b1;
    #1;
    check("col_wready", WREADY, 1);
    model[16] = 32'h55;
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
    check("col_bvalid", BVALID, 1);
    check("col_bresp", BRESP, 0);
    BREADY = 1'b1; tick(); BREADY = 1'b0;
    do_read(32'h40, 8'd0, 1'b0);

    // Index wraps from the last word to word 0.
    do_write(32'hFFC, 8'd1, 32'hA, 2, 1, 2'b00);
    check("wrap_model_hi", model[1023], 32'hA);
    do_read(32'hFFC, 8'd1, 1'b0);

    // Reset in the middle of a read burst.
    ARADDR = 32'h10; ARLEN = 8'd3; ARVALID = 1'b1;
    #1;
    k = 0;
    while (!ARREADY && k < 20) begin tick(); #1; k++; end
    tick();
    ARVALID = 1'b0;
    k = 0;
    while (!RVALID && k < 10) begin tick(); k++; end
    check("mid_rvalid_seen", RVALID, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_rvalid", RVALID, 0);
    check("mid_rst_rlast", RLAST, 0);
    check("mid_rst_arready", ARREADY, 0);
    check("mid_rst_rdata", RDATA, 0);
    rst = 1'b0;
    tick();
    do_read(32'h10, 8'd3, 1'b0);

`ifdef AXI_SLV_RESP_CHECK_EN
    do_write(32'h80, 8'd3, 32'h100, 2, 1, 2'b10);
    do_read(32'h80, 8'd1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
